serial_digit_adder: RTL and testbench



---
 rtl/serial_digit_adder_pkg.sv | 18 +
 rtl/serial_digit_adder_digit.sv | 20 ++
 rtl/serial_digit_adder.sv | 118 +++++++++++
 tb/tb_serial_digit_adder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_digit_adder_pkg.sv
// Shared definitions for the serial digit adder: FSM encoding and the
// counter-width helper used to size the digit counter.
package serial_digit_adder_pkg;

    // FSM encoding kept as plain constants so older blocks can reuse it.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Ceiling log2 with a floor of 1 so a single-digit build still gets
    // a legal one-bit counter.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/serial_digit_adder_digit.sv
// Combinational DIGIT-bit adder slice reused on every RUN cycle.
module digit_adder
    import serial_digit_adder_pkg::*;
#(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    logic [DIGIT:0] total;

    // One extra bit on the sum captures the digit carry-out.
    assign total   = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
    assign {co, s} = total;

endmodule

// File: rtl/serial_digit_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are processed DIGIT bits
// per clock, least significant digit first, with the carry held in a flop
// between digits.
//
// Handshake: start is sampled only on an edge where busy=0; that edge captures
// a, b, sub and cin and raises busy. busy stays high for NDIG cycles; on the
// edge that finishes the last digit busy drops and done pulses for exactly one
// cycle while sum/cout/ovf take their new values. start seen while busy=1 is
// dropped, and a start held during the done cycle is accepted immediately.
module serial_digit_adder
    import serial_digit_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done,
    output logic [0:0]       state_dbg
);

    localparam int            NDIG = WIDTH / DIGIT;
    localparam int            CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             c;
    logic             a_msb;
    logic             b_msb;

    logic [DIGIT-1:0] d_s;
    logic             d_co;
    logic [WIDTH-1:0] res_next;
    logic             ovf_next;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x  (a_sr[DIGIT-1:0]),
        .y  (b_sr[DIGIT-1:0]),
        .ci (c),
        .s  (d_s),
        .co (d_co)
    );

    // New digit enters the result register from the MSB end; after NDIG
    // shifts the first digit has reached bit 0.
    assign res_next = (res_sr >> DIGIT) | (WIDTH'(d_s) << (WIDTH - DIGIT));

    // Signed overflow: operands agree in sign but the result does not.
    assign ovf_next = (a_msb == b_msb) && (res_next[WIDTH-1] != a_msb);

    assign busy      = (state == ST_RUN);
    assign state_dbg = state;

    // FSM, operand shift registers, digit counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            c      <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1; cin is ignored then.
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        c     <= sub ? 1'b1 : cin;
                        a_msb <= a[WIDTH-1];
                        b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sr   <= a_sr >> DIGIT;
                    b_sr   <= b_sr >> DIGIT;
                    res_sr <= res_next;
                    c      <= d_co;
                    if (cnt == LAST) begin
                        sum   <= res_next;
                        cout  <= d_co;
                        ovf   <= ovf_next;
                        done  <= 1'b1;
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_digit_adder.sv
// Bench for serial_digit_adder: directed vectors on a WIDTH=8/DIGIT=2 build
// checked every cycle against a transaction-level model, plus a random sweep
// over DIGIT = 1, 2, 4, 8.
module tb_serial_digit_adder;

    localparam int NDIG = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic sw_rst_n;
    always #5 clk = ~clk;

    // ---------------- directed DUT ----------------
    logic       start, sub, cin;
    logic [7:0] a, b;
    logic [7:0] sum;
    logic       cout, ovf, busy, done;
    logic [0:0] state_dbg;

    serial_digit_adder #(.WIDTH(8), .DIGIT(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .cin       (cin),
        .a         (a),
        .b         (b),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    int n_checks   = 0;
    int n_errors   = 0;
    int sweep_fin  = 0;
    bit sweep_go   = 1'b0;
    bit cmp_en     = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference arithmetic on whole integers: returns {cout, ovf, sum}.
    function automatic logic [9:0] ref_calc(input logic [7:0] ra, input logic [7:0] rb,
                                            input logic rs, input logic rc);
        int ua, ub, sa, sb, t, st;
        logic c_o, o_f;
        ua = int'(ra);
        ub = int'(rb);
        sa = int'($signed(ra));
        sb = int'($signed(rb));
        if (rs) begin
            t   = ua - ub;
            st  = sa - sb;
            c_o = (ua >= ub);
        end else begin
            t   = ua + ub + int'(rc);
            st  = sa + sb + int'(rc);
            c_o = (t > 255);
        end
        o_f = (st > 127) || (st < -128);
        return {c_o, o_f, 8'(t)};
    endfunction

    // ---------------- model + scoreboard ----------------
    logic [9:0] exp_q[$];
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [7:0] m_sum  = 8'h00;
    logic       m_cout = 1'b0;
    logic       m_ovf  = 1'b0;
    int         m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_busy = 1'b0;
            m_done = 1'b0;
            m_sum  = 8'h00;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
            m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    {m_cout, m_ovf, m_sum} = exp_q.pop_front();
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (start) begin
                exp_q.push_back(ref_calc(a, b, sub, cin));
                m_busy = 1'b1;
                m_left = NDIG;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy", int'(busy), int'(m_busy));
            chk("cyc_done", int'(done), int'(m_done));
            chk("cyc_sum",  int'(sum),  int'(m_sum));
            chk("cyc_cout", int'(cout), int'(m_cout));
            chk("cyc_ovf",  int'(ovf),  int'(m_ovf));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic op_check(input string name, input logic [7:0] ta, input logic [7:0] tbv,
                            input logic ts, input logic tc, input logic [7:0] es,
                            input logic ec, input logic eo);
        int n;
        @(negedge clk);
        a = ta; b = tbv; sub = ts; cin = tc; start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end while (!done && n < 40);
        chk({name, "_lat"},  n - 1, NDIG);
        chk({name, "_sum"},  int'(sum),  int'(es));
        chk({name, "_cout"}, int'(cout), int'(ec));
        chk({name, "_ovf"},  int'(ovf),  int'(eo));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        rst_n = 1'b0; sw_rst_n = 1'b0;
        start = 1'b0; sub = 1'b0; cin = 1'b0; a = 8'h00; b = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_sum",  int'(sum),  0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_flags", int'({cout, ovf}), 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        op_check("add_5a_3c",  8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
        op_check("add_ff_01",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op_check("add_cin",    8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
        op_check("sub_10_20",  8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        op_check("sub_80_01",  8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);

        // Start while busy is dropped; start held through done launches next op.
        @(negedge clk);
        a = 8'h33; b = 8'h11; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 8'h01; b = 8'h01; start = 1'b1;
        n = 2;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("busy_first_lat", n - 1, NDIG);
        chk("busy_first_sum", int'(sum), 8'h44);
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end while (!done && n < 40);
        chk("held_start_lat", n - 1, NDIG);
        chk("held_start_sum", int'(sum), 8'h02);

        // Asynchronous reset in the second RUN cycle.
        @(negedge clk);
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sum",  int'(sum),  0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_flags", int'({cout, ovf}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("arst_no_done", int'(done), 0);
        end
        op_check("after_rst",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

        // Random sweep over all digit sizes.
        sw_rst_n = 1'b1;
        sweep_go = 1'b1;
        for (int i = 0; i < 20000 && sweep_fin < 4; i++) @(negedge clk);
        chk("sweep_complete", sweep_fin, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // ---------------- sweep instances ----------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_sw
        localparam int DG = 1 << gi;
        localparam int ND = 8 / DG;
        logic       s_start, s_sub, s_cin;
        logic [7:0] s_a, s_b, s_sum;
        logic       s_cout, s_ovf, s_busy, s_done;
        logic [0:0] s_state;

        serial_digit_adder #(.WIDTH(8), .DIGIT(DG)) u_sw (
            .clk       (clk),
            .rst_n     (sw_rst_n),
            .start     (s_start),
            .sub       (s_sub),
            .cin       (s_cin),
            .a         (s_a),
            .b         (s_b),
            .sum       (s_sum),
            .cout      (s_cout),
            .ovf       (s_ovf),
            .busy      (s_busy),
            .done      (s_done),
            .state_dbg (s_state)
        );

        initial begin
            int         n;
            logic [9:0] e;
            s_start = 1'b0; s_sub = 1'b0; s_cin = 1'b0; s_a = 8'h00; s_b = 8'h00;
            wait (sweep_go);
            for (int k = 0; k < 1000; k++) begin
                @(negedge clk);
                s_a   = 8'($urandom_range(0, 255));
                s_b   = 8'($urandom_range(0, 255));
                s_sub = 1'($urandom_range(0, 1));
                s_cin = 1'($urandom_range(0, 1));
                s_start = 1'b1;
                e = ref_calc(s_a, s_b, s_sub, s_cin);
                n = 0;
                do begin
                    @(negedge clk);
                    s_start = 1'b0;
                    n++;
                end while (!s_done && n < 40);
                chk($sformatf("sweep_d%0d_lat", DG), n - 1, ND);
                chk($sformatf("sweep_d%0d_res", DG), int'({s_cout, s_ovf, s_sum}), int'(e));
            end
            sweep_fin++;
        end
    end

endmodule
